// File: rtl/fft_out_reorder.sv
// fft_out_reorder
//   Reorder stage behind the in-place FFT core. It takes two complex bins per
//   cycle in bit-reversed pair order and buffers a whole frame in a ping-pong
//   memory (buffers A/B). Each buffer is split into a lower and an upper half,
//   so both bins of a pair are written in the same cycle. The frame is then
//   streamed out one bin per cycle under a valid/ready handshake.
//
//   Build option: FFT_REORDER_NATURAL_EN
//     defined   : bins are stored at their true index and leave in natural order.
//     undefined : pairs are stored in arrival order and leave in arrival order.
//                 out_idx still reports the true bin index.
//
//   Ports
//     clk_i                     clock, rising edge
//     nrst_i                    synchronous active-low reset
//     in_valid_i / in_sof_i     input pair present / pair is pair 0 of a frame
//     in_real0_i, in_imag0_i    upper butterfly output
//     in_real1_i, in_imag1_i    lower butterfly output
//     out_valid_o, out_ready_i  output handshake
//     out_real_o, out_imag_o    output bin
//     out_idx_o                 bin index of the current output
//     out_last_o                high with bin N-1
//     ovf_o                     sticky: a frame was dropped
//
//   Read FSM
//     state    | meaning
//     R_IDLE   | wait for full[rsel]
//     R_PRIME  | read bin 0 into the output registers
//     R_STREAM | out_valid high, advance one position per handshake
module fft_out_reorder #(
    parameter int BW    = 16,
    parameter int LOG2N = 6
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             in_valid_i,
    input  logic             in_sof_i,
    input  logic [BW-1:0]    in_real0_i,
    input  logic [BW-1:0]    in_imag0_i,
    input  logic [BW-1:0]    in_real1_i,
    input  logic [BW-1:0]    in_imag1_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [BW-1:0]    out_real_o,
    output logic [BW-1:0]    out_imag_o,
    output logic [LOG2N-1:0] out_idx_o,
    output logic             out_last_o,
    output logic             ovf_o
);
    localparam int HW = LOG2N - 1;
    localparam int N  = 1 << LOG2N;
    localparam logic [HW-1:0]    LAST_PAIR = '1;
    localparam logic [LOG2N-1:0] LAST_POS  = '1;

    typedef enum logic [1:0] {R_IDLE, R_PRIME, R_STREAM} rstate_t;

    // Each half memory is indexed by {buffer, half address}.
    logic [2*BW-1:0] mem_lo_q [N];
    logic [2*BW-1:0] mem_hi_q [N];

    logic [HW-1:0]    wcnt_q, wcnt_d;
    logic             wsel_q, wsel_d;
    logic             drop_q, drop_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       full_q, full_d;
    logic [HW-1:0]    pair_idx;
    logic [HW-1:0]    wr_addr;
    logic             wr_en;
    logic             wr_set;

    rstate_t          rstate_q;
    logic             rsel_q;
    logic [LOG2N-1:0] rpos_q;
    logic             out_valid_q;
    logic [BW-1:0]    out_real_q, out_imag_q;
    logic [LOG2N-1:0] out_idx_q;
    logic             out_last_q;
    logic             hs;
    logic             rd_clr;
    logic [LOG2N-1:0] rd_pos;
    logic [LOG2N-1:0] rd_bin;
    logic [HW-1:0]    rd_addr;
    logic             rd_half;
    logic [2*BW-1:0]  rd_word;

    function automatic logic [HW-1:0] rev_half(input logic [HW-1:0] a);
        logic [HW-1:0] r;
        for (int i = 0; i < HW; i++) r[i] = a[HW-1-i];
        return r;
    endfunction

    function automatic logic [LOG2N-1:0] rev_full(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    // ---------------------------------------------------------------- write side
    // br(2k) is the bit reversal of k within the half, so both bins of pair k
    // share one half address in natural mode.
`ifdef FFT_REORDER_NATURAL_EN
    assign wr_addr = rev_half(pair_idx);
`else
    assign wr_addr = pair_idx;
`endif

    always_comb begin
        pair_idx = in_sof_i ? '0 : wcnt_q;
        wcnt_d   = wcnt_q;
        wsel_d   = wsel_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        wr_set   = 1'b0;
        if (in_valid_i) begin
            // Keep or drop is decided once, on pair 0; the counter keeps
            // running through a dropped frame so alignment is preserved.
            if (pair_idx == '0) begin
                drop_d = full_q[wsel_q];
                wr_en  = !full_q[wsel_q];
                if (full_q[wsel_q]) ovf_d = 1'b1;
            end else begin
                wr_en = !drop_q;
            end
            wcnt_d = pair_idx + 1'b1;
            if (pair_idx == LAST_PAIR && wr_en) begin
                wr_set = 1'b1;
                wsel_d = !wsel_q;
            end
        end
    end

    always_comb begin
        full_d = full_q;
        if (wr_set) full_d[wsel_q] = 1'b1;
        if (rd_clr) full_d[rsel_q] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            wcnt_q <= '0;
            wsel_q <= 1'b0;
            drop_q <= 1'b0;
            ovf_q  <= 1'b0;
            full_q <= 2'b00;
        end else begin
            wcnt_q <= wcnt_d;
            wsel_q <= wsel_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
            full_q <= full_d;
        end
    end

    // Contents are deliberately not reset; only the full flags qualify them.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_lo_q[{wsel_q, wr_addr}] <= {in_real0_i, in_imag0_i};
            mem_hi_q[{wsel_q, wr_addr}] <= {in_real1_i, in_imag1_i};
        end
    end

    // ----------------------------------------------------------------- read side
    assign hs     = out_valid_q & out_ready_i;
    assign rd_clr = (rstate_q == R_STREAM) && hs && (rpos_q == LAST_POS);
    assign rd_pos = (rstate_q == R_PRIME) ? '0 : rpos_q + 1'b1;

`ifdef FFT_REORDER_NATURAL_EN
    assign rd_half = rd_pos[LOG2N-1];
    assign rd_addr = rd_pos[HW-1:0];
    assign rd_bin  = rd_pos;
`else
    // Even arrival positions live in the lower half, odd ones in the upper.
    assign rd_half = rd_pos[0];
    assign rd_addr = rd_pos[LOG2N-1:1];
    assign rd_bin  = rev_full(rd_pos);
`endif

    assign rd_word = rd_half ? mem_hi_q[{rsel_q, rd_addr}] : mem_lo_q[{rsel_q, rd_addr}];

    // The output registers are the synchronous read registers of the memory.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            rstate_q    <= R_IDLE;
            rsel_q      <= 1'b0;
            rpos_q      <= '0;
            out_valid_q <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (full_q[rsel_q]) rstate_q <= R_PRIME;
                end
                R_PRIME: begin
                    out_valid_q <= 1'b1;
                    out_real_q  <= rd_word[2*BW-1:BW];
                    out_imag_q  <= rd_word[BW-1:0];
                    rpos_q      <= rd_pos;
                    out_idx_q   <= rd_bin;
                    out_last_q  <= (rd_pos == LAST_POS);
                    rstate_q    <= R_STREAM;
                end
                R_STREAM: begin
                    if (hs) begin
                        if (rpos_q == LAST_POS) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            rsel_q      <= !rsel_q;
                            rstate_q    <= full_q[!rsel_q] ? R_PRIME : R_IDLE;
                        end else begin
                            out_real_q <= rd_word[2*BW-1:BW];
                            out_imag_q <= rd_word[BW-1:0];
                            rpos_q     <= rd_pos;
                            out_idx_q  <= rd_bin;
                            out_last_q <= (rd_pos == LAST_POS);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_real_o  = out_real_q;
    assign out_imag_o  = out_imag_q;
    assign out_idx_o   = out_idx_q;
    assign out_last_o  = out_last_q;
    assign ovf_o       = ovf_q;

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder stage directly downstream of the in-place FFT core. Accepts the core's butterfly output two complex bins per cycle in bit-reversed pair order, buffers a full 64-point frame in a ping-pong memory and streams it out one bin per cycle in natural order under a valid/ready handshake. Decouples the core's fixed-rate output from a back-pressuring consumer such as a magnitude or DMA stage.

## Interface
- BW, 16, bits per real/imag component (two's complement)
- LOG2N, 6, log2 of FFT size; N = 64, pairs per frame = N/2 = 32

- clk  in  1  clock, rising edge
- nrst  in  1  synchronous active-low reset
- in_valid  in  1  input pair present this cycle
- in_sof  in  1  qualifies in_valid: this pair is pair 0 of a frame
- in_real0, in_imag0  in  BW each  upper butterfly output
- in_real1, in_imag1  in  BW each  lower butterfly output
- out_valid  out  1  output sample valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_real, out_imag  out  BW each  output bin
- out_idx  out  LOG2N  bin index of current output
- out_last  out  1  high with bin N-1
- ovf  out  1  sticky: a frame was dropped

## Operation
- Two frame buffers (A/B), each split into lower half (bins 0..31) and upper half (bins 32..63); one write per half per cycle.
- Pair k (0..31 within frame) carries bin br(2k) on upper port and br(2k)+32 on lower port, br = LOG2N-bit bit reversal. Upper port writes address br(2k) of lower half, lower port writes address br(2k) of upper half.
- Write side: pair counter wcnt (5 bit), buffer select wsel. in_valid & in_sof forces wcnt to 0 for that pair (partial frame abandoned, buffer not marked full). Without in_sof, wcnt increments per in_valid. Pair 31 written -> full[wsel] set, wsel toggles, wcnt wraps to 0.
- Drop: if full[wsel] is set when pair 0 arrives, entire frame is discarded (writes suppressed, wcnt still advances for alignment), ovf set. ovf cleared only by reset.
- Read side FSM, buffer select rsel:
  - R_IDLE: wait full[rsel]; -> R_PRIME.
  - R_PRIME: issue read of bin 0; -> R_STREAM.
  - R_STREAM: out_valid=1; on handshake, advance out_idx, prefetch next bin. Handshake on bin 63 clears full[rsel], toggles rsel, -> R_PRIME if full[~rsel] already set, else R_IDLE.
- Output registers hold stable while out_valid & !out_ready.
- Simultaneous set of full[x] by writer and clear of full[y] by reader in the same cycle both take effect.

## Timing
- Reset values: out_valid 0, out_real/out_imag 0, out_idx 0, out_last 0, ovf 0, full 00, wsel=rsel=A, wcnt 0, FSM R_IDLE.
- Memory read synchronous, one cycle.
- Latency: edge writing pair 31 = cycle T; out_valid high at T+2 with bin 0.
- Throughput: one bin per cycle with out_ready held high; back-to-back frames stream with one idle bubble (R_PRIME) per frame.
- Input rate: one pair per cycle sustained; buffer drains 64 bins in ≥64 cycles vs 32-cycle fill, so sustained back-to-back input with out_ready high overflows on the third frame — expected, flagged by ovf.
- Reset asserted mid-frame: all state cleared next edge; buffered data discarded (contents not cleared, full flags are).

## Configuration
- FFT_REORDER_NATURAL_EN defined: addressing as above, natural-order output.
- Undefined: write addresses are arrival order (upper -> 2k, lower -> 2k+1); out_idx still reports true bin index br(j) for output position j. All timing, handshake and ovf behaviour identical.

## Test plan
- Reset then one frame, pair k = {upper=br(2k), lower=br(2k)+32} in real, imag=-real, out_ready=1 -> out_valid at T+2, out_real=0..63 sequentially, out_imag=-out_real, out_last only on idx 63, ovf=0.
- Same frame, out_ready toggled 1010... -> identical sequence, outputs stable while stalled, 128 cycles for drain.
- Three back-to-back frames, out_ready=0 until frame 3 ends -> frames 1,2 stored, frame 3 dropped, ovf=1; then out_ready=1 -> frames 1 and 2 out in order, 1-cycle gap between.
- in_sof at pair 10 of frame 1 -> first 10 pairs abandoned, new frame completes 31 pairs later, only new frame output.
- nrst low for one cycle at bin 20 of output -> next cycle out_valid=0, ovf=0; following clean frame outputs bins 0..63 correctly.
- Build without FFT_REORDER_NATURAL_EN, same stimulus as test 1 -> out_real sequence 0,32,16,48,... with out_idx equal to out_real.
